tournament_predictor: RTL

TOURNAMENT_PREDICTOR -- requirements
Module: tournament_predictor

---
 rtl/bp_pkg.sv | 23 ++
 rtl/bp_pht.sv | 28 ++
 rtl/tournament_predictor.sv | 122 ++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the tournament branch predictor:
// 2-bit saturating counters and the init/run state encoding.
package bp_pkg;

   typedef logic [1:0] cnt_t;

   localparam cnt_t CNT_INIT = 2'b01;
   localparam cnt_t CNT_MAX  = 2'b11;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   function automatic cnt_t sat_inc(input cnt_t c);
      return (c == CNT_MAX) ? c : cnt_t'(c + 2'b01);
   endfunction

   function automatic cnt_t sat_dec(input cnt_t c);
      return (c == 2'b00) ? c : cnt_t'(c - 2'b01);
   endfunction

endpackage

// File: rtl/bp_pht.sv
// Table of 2-bit counters: asynchronous query and update read ports, one
// synchronous write port shared by the init sweep and the update path.
module bp_pht
   import bp_pkg::*;
#(
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic [AW-1:0] q_idx,
   output cnt_t          q_cnt,
   input  logic [AW-1:0] u_idx,
   output cnt_t          u_cnt,
   input  logic          we,
   input  logic [AW-1:0] w_idx,
   input  cnt_t          w_data
);

   // Contents are not reset; the owner sweeps every entry after reset.
   cnt_t mem [2**AW];

   assign q_cnt = mem[q_idx];
   assign u_cnt = mem[u_idx];

   always_ff @(posedge clk) begin
      if (we) mem[w_idx] <= w_data;
   end

endmodule

// File: rtl/tournament_predictor.sv
// Tournament predictor: per-tag local history feeding a local PHT, a gshare
// global PHT, and a chooser that picks between them per global index.
module tournament_predictor
   import bp_pkg::*;
#(
   parameter int TAG_LEN     = 10,
   parameter int LOCAL_HLEN  = 8,
   parameter int GLOBAL_HLEN = 12
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               upd_valid,
   input  logic [TAG_LEN-1:0] upd_tag,
   input  logic               upd_taken,
   input  logic [TAG_LEN-1:0] q_tag,
   output logic               q_taken,
   output logic               q_src,
   output logic               ready
);

   localparam int MAXW_LG = (LOCAL_HLEN > GLOBAL_HLEN) ? LOCAL_HLEN : GLOBAL_HLEN;
   localparam int MAXW    = (TAG_LEN > MAXW_LG) ? TAG_LEN : MAXW_LG;

   localparam logic [MAXW:0] DEP_TAG = (MAXW+1)'(1) << TAG_LEN;
   localparam logic [MAXW:0] DEP_LH  = (MAXW+1)'(1) << LOCAL_HLEN;
   localparam logic [MAXW:0] DEP_GH  = (MAXW+1)'(1) << GLOBAL_HLEN;

   state_t                 state;
   logic [MAXW-1:0]        idx;
   logic [GLOBAL_HLEN-1:0] ghist;
   logic [LOCAL_HLEN-1:0]  lhist [2**TAG_LEN];

   logic                   init_mode, fire;
   logic                   in_tag, in_lh, in_gh;
   logic [LOCAL_HLEN-1:0]  lq_idx, lu_idx;
   logic [GLOBAL_HLEN-1:0] gq_idx, gu_idx;
   cnt_t                   lq_cnt, lu_cnt, gq_cnt, gu_cnt, cq_cnt, cu_cnt;
   logic                   l_we, g_we, c_we;
   logic [LOCAL_HLEN-1:0]  l_widx;
   logic [GLOBAL_HLEN-1:0] g_widx;
   cnt_t                   l_wdata, g_wdata, c_wdata;

   assign init_mode = (state == ST_INIT);
   assign fire      = upd_valid && ready;

   // A table takes the sweep write only while the index is within its depth.
   assign in_tag = {1'b0, idx} < DEP_TAG;
   assign in_lh  = {1'b0, idx} < DEP_LH;
   assign in_gh  = {1'b0, idx} < DEP_GH;

   assign lq_idx = lhist[q_tag];
   assign lu_idx = lhist[upd_tag];
   assign gq_idx = ghist ^ GLOBAL_HLEN'(q_tag);
   assign gu_idx = ghist ^ GLOBAL_HLEN'(upd_tag);

   assign l_we    = init_mode ? in_lh : fire;
   assign l_widx  = init_mode ? idx[LOCAL_HLEN-1:0] : lu_idx;
   assign l_wdata = init_mode ? CNT_INIT : (upd_taken ? sat_inc(lu_cnt) : sat_dec(lu_cnt));

   assign g_we    = init_mode ? in_gh : fire;
   assign g_widx  = init_mode ? idx[GLOBAL_HLEN-1:0] : gu_idx;
   assign g_wdata = init_mode ? CNT_INIT : (upd_taken ? sat_inc(gu_cnt) : sat_dec(gu_cnt));

   // Chooser trains only on disagreement, toward whichever component was right.
   assign c_we    = init_mode ? in_gh : (fire && (lu_cnt[1] != gu_cnt[1]));
   assign c_wdata = init_mode ? CNT_INIT :
                    ((gu_cnt[1] == upd_taken) ? sat_inc(cu_cnt) : sat_dec(cu_cnt));

   bp_pht #(.AW(LOCAL_HLEN)) u_lpht (
      .clk(clk), .q_idx(lq_idx), .q_cnt(lq_cnt), .u_idx(lu_idx), .u_cnt(lu_cnt),
      .we(l_we), .w_idx(l_widx), .w_data(l_wdata)
   );

   bp_pht #(.AW(GLOBAL_HLEN)) u_gpht (
      .clk(clk), .q_idx(gq_idx), .q_cnt(gq_cnt), .u_idx(gu_idx), .u_cnt(gu_cnt),
      .we(g_we), .w_idx(g_widx), .w_data(g_wdata)
   );

   bp_pht #(.AW(GLOBAL_HLEN)) u_chooser (
      .clk(clk), .q_idx(gq_idx), .q_cnt(cq_cnt), .u_idx(gu_idx), .u_cnt(cu_cnt),
      .we(c_we), .w_idx(g_widx), .w_data(c_wdata)
   );

   assign q_src   = ready && cq_cnt[1];
   assign q_taken = ready && (cq_cnt[1] ? gq_cnt[1] : lq_cnt[1]);

   always_ff @(posedge clk) begin
      if (init_mode && in_tag)
         lhist[idx[TAG_LEN-1:0]] <= '0;
      else if (fire)
         lhist[upd_tag] <= {lu_idx[LOCAL_HLEN-2:0], upd_taken};
   end

   // INIT holds the index at its last value on exit; only reset rewinds it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_INIT;
         idx   <= '0;
         ghist <= '0;
         ready <= 1'b0;
      end else begin
         case (state)
            ST_INIT: begin
               if (idx == {MAXW{1'b1}}) begin
                  state <= ST_RUN;
                  ready <= 1'b1;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            ST_RUN: begin
               if (upd_valid) ghist <= {ghist[GLOBAL_HLEN-2:0], upd_taken};
            end
            default: begin
               state <= ST_INIT;
               ready <= 1'b0;
            end
         endcase
      end
   end

endmodule
